uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 89 ++++++++
 tb/tb_uart_rx_fifo.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the stopwatch command logic.
// First-word fall-through; define RX_FIFO_OVF_EN to enable the sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH_LOG2'(0) + (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push, pop, ovf_evt;

  // Flags come from the count register; pointer equality is ambiguous at full/empty.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;

  assign pop     = rd_en & ~empty;
  assign push    = rx_done & (~full | pop);
  assign ovf_evt = rx_done & full & ~pop;

  assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef RX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_evt) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, ovf_evt};
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DEPTH_LOG2=3; follows RX_FIFO_OVF_EN for ovf expectations.
module tb_uart_rx_fifo;

  localparam int DL2 = 3;
`ifdef RX_FIFO_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic           clk, rst_n;
  logic [7:0]     rx_data;
  logic           rx_done, rd_en, ovf_clr;
  logic [7:0]     rd_data;
  logic           empty, full, ovf;
  logic [DL2:0]   count;

  int total = 0;
  int bad   = 0;
  logic [7:0] q [$];

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic [7:0] b, input logic r, input logic c);
    rx_done = d; rx_data = b; rd_en = r; ovf_clr = c;
    @(posedge clk); #1;
    rx_done = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);

    // single byte round trip
    step(1, 8'h41, 0, 0);
    chk("one_rd_data", rd_data, 8'h41);
    chk("one_empty", empty, 0);
    chk("one_count", count, 1);
    step(0, 8'h00, 1, 0);
    chk("one_pop_empty", empty, 1);
    chk("one_pop_rd_data", rd_data, 8'h00);

    step(0, 8'h00, 1, 0);
    chk("pop_empty_count", count, 0);
    chk("pop_empty_empty", empty, 1);

    // fill, overflow, drain
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_head", rd_data, 8'h01);
    step(1, 8'hFF, 0, 0);
    chk("ovf_count", count, 8);
    chk("ovf_set", ovf, OVF_ON);
    chk("ovf_head", rd_data, 8'h01);
    step(1, 8'hFE, 0, 1);
    chk("ovf_set_wins", ovf, OVF_ON);
    chk("ovf_sticky_count", count, 8);
    step(0, 8'h00, 0, 1);
    chk("ovf_clr", ovf, 0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), rd_data, 8'(i));
      step(0, 8'h00, 1, 0);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // simultaneous push+pop while full
    for (int i = 0; i < 8; i++) step(1, 8'h10 + 8'(i), 0, 0);
    step(1, 8'h55, 1, 0);
    chk("fullpp_count", count, 8);
    chk("fullpp_full", full, 1);
    chk("fullpp_head", rd_data, 8'h11);
    chk("fullpp_ovf", ovf, 0);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("fullpp_pop_%0d", i), rd_data, 8'h10 + 8'(i));
      step(0, 8'h00, 1, 0);
    end
    chk("fullpp_last", rd_data, 8'h55);
    step(0, 8'h00, 1, 0);
    chk("fullpp_empty", empty, 1);

    // simultaneous push+pop while empty
    step(1, 8'h33, 1, 0);
    chk("emptypp_count", count, 1);
    chk("emptypp_rd_data", rd_data, 8'h33);
    step(0, 8'h00, 1, 0);
    chk("emptypp_drain", empty, 1);

    // interleaved traffic across pointer wrap, checked against a queue
    for (int i = 0; i < 12; i++) begin
      logic do_pop;
      do_pop = i[0];
      if (do_pop) void'(q.pop_front());
      q.push_back(8'h80 + 8'(i));
      step(1, 8'h80 + 8'(i), do_pop, 0);
      chk($sformatf("ilv_count_%0d", i), count, q.size());
      chk($sformatf("ilv_head_%0d", i), rd_data, q[0]);
    end
    while (q.size() > 0) begin
      chk("ilv_drain", rd_data, q.pop_front());
      step(0, 8'h00, 1, 0);
    end
    chk("ilv_empty", empty, 1);

    // asynchronous reset mid-operation
    step(1, 8'hC1, 0, 0);
    step(1, 8'hC2, 0, 0);
    step(1, 8'hC3, 0, 0);
    chk("pre_rst_count", count, 3);
    #2; rst_n = 1'b0; #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_rd_data", rd_data, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    step(1, 8'hD1, 0, 0);
    chk("post_rst_count", count, 1);
    chk("post_rst_head", rd_data, 8'hD1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
